// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART_RX sequencing controller
// Purpose: controller FSM state encoding, reset-time receiver configuration,
//          the legal oversampling factors and the default timing parameters.
// Ports:   none (package).
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE_WAIT = 2'd0,
    IDLE      = 2'd1,
    FRAME     = 2'd2
  } state_e;

  localparam logic       RST_PAR_EN   = 1'b1;
  localparam logic       RST_PAR_TYP  = 1'b0;
  localparam logic [5:0] RST_PRESCALE = 6'd8;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam int DEF_IDLE_BITS    = 2;
  localparam int DEF_TIMEOUT_BITS = 12;

  function automatic logic is_legal_prescale(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// rtl/rx_byte_fifo.sv - first-word-fall-through byte FIFO with sticky overrun
// Purpose: buffers received bytes for a valid/ready consumer.
// Ports:   clk, rst         clock, async active-high reset
//          in_valid/in_data byte push strobe and data
//          out_data/out_valid head byte, non-empty flag
//          out_ready        consumer accept (pop when out_valid)
//          count            occupancy, overrun sticky drop flag, ovr_clr clear
module rx_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun,
  input  logic                     ovr_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          full, pop, push, drop;

  assign full      = (count_q == CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_data = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign count    = count_q;
  assign overrun  = overrun_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - configuration, frame watchdog and byte buffering beside UART_RX
// Purpose: owns UART_RX PAR_EN/PAR_TYP/Prescale, applies host config only when
//          the line has been idle, times out frames that never deliver a byte,
//          and queues received bytes for a valid/ready consumer.
// Ports:   CLK, RST                    clock, async active-high reset
//          RX_IN                       serial line (already synchronous)
//          cfg_wr/cfg_par_en/cfg_par_typ/cfg_prescale  host config write
//          PAR_EN/PAR_TYP/Prescale     active config to UART_RX
//          P_DATA/data_valid           byte from UART_RX
//          m_data/m_valid/m_ready      consumer stream, fifo_count occupancy
//          cfg_pending, cfg_err, frame_err, overrun/ovr_clr  status
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int IDLE_BITS    = DEF_IDLE_BITS,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RX_IN,
  input  logic                          cfg_wr,
  input  logic                          cfg_par_en,
  input  logic                          cfg_par_typ,
  input  logic [5:0]                    cfg_prescale,
  output logic                          PAR_EN,
  output logic                          PAR_TYP,
  output logic [5:0]                    Prescale,
  input  logic [7:0]                    P_DATA,
  input  logic                          data_valid,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          cfg_pending,
  output logic                          cfg_err,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          ovr_clr
);

  state_e     state_q, state_d;
  logic       prev_rx_q, prev_rx_d;
  logic [7:0] idle_cnt_q, idle_cnt_d;
  logic [9:0] tmo_cnt_q, tmo_cnt_d;
  logic       par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic [5:0] prescale_q, prescale_d;
  logic       sh_par_en_q, sh_par_en_d, sh_par_typ_q, sh_par_typ_d;
  logic [5:0] sh_prescale_q, sh_prescale_d;
  logic       cfg_pending_q, cfg_pending_d;
  logic       cfg_err_q, cfg_err_d;
  logic       frame_err_q, frame_err_d;

  logic        start_edge;
  logic [15:0] idle_lim, tmo_lim;

  assign start_edge = prev_rx_q && !RX_IN;
  // Thresholds track the active prescale, which cannot change outside IDLE.
  assign idle_lim   = 16'(IDLE_BITS) * 16'(prescale_q) - 16'd1;
  assign tmo_lim    = 16'(TIMEOUT_BITS) * 16'(prescale_q) - 16'd1;

  always_comb begin
    state_d       = state_q;
    prev_rx_d     = RX_IN;
    idle_cnt_d    = idle_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    par_en_d      = par_en_q;
    par_typ_d     = par_typ_q;
    prescale_d    = prescale_q;
    sh_par_en_d   = sh_par_en_q;
    sh_par_typ_d  = sh_par_typ_q;
    sh_prescale_d = sh_prescale_q;
    cfg_pending_d = cfg_pending_q;
    cfg_err_d     = 1'b0;
    frame_err_d   = 1'b0;

    case (state_q)
      IDLE_WAIT: begin
        if (start_edge) begin
          state_d   = FRAME;
          tmo_cnt_d = '0;
        end else if (!RX_IN) begin
          idle_cnt_d = '0;
        end else begin
          if ({8'd0, idle_cnt_q} == idle_lim) begin
            state_d = IDLE;
          end
          if (idle_cnt_q != '1) begin
            idle_cnt_d = idle_cnt_q + 8'd1;
          end
        end
      end
      IDLE: begin
        if (start_edge) begin
          state_d   = FRAME;
          tmo_cnt_d = '0;
        end else if (cfg_pending_q) begin
          par_en_d      = sh_par_en_q;
          par_typ_d     = sh_par_typ_q;
          prescale_d    = sh_prescale_q;
          cfg_pending_d = 1'b0;
        end
      end
      FRAME: begin
        if (tmo_cnt_q != '1) begin
          tmo_cnt_d = tmo_cnt_q + 10'd1;
        end
        // A byte arriving on the timeout cycle still counts as a good frame.
        if (data_valid) begin
          state_d    = IDLE_WAIT;
          idle_cnt_d = '0;
        end else if ({6'd0, tmo_cnt_q} == tmo_lim) begin
          frame_err_d = 1'b1;
          state_d     = IDLE_WAIT;
          idle_cnt_d  = '0;
        end
      end
      default: state_d = IDLE_WAIT;
    endcase

    // Evaluated after the apply so a coincident write re-arms cfg_pending
    // while the apply above consumed the previous shadow value.
    if (cfg_wr) begin
      if (is_legal_prescale(cfg_prescale)) begin
        sh_par_en_d   = cfg_par_en;
        sh_par_typ_d  = cfg_par_typ;
        sh_prescale_d = cfg_prescale;
        cfg_pending_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE_WAIT;
      prev_rx_q     <= 1'b1;
      idle_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      par_en_q      <= RST_PAR_EN;
      par_typ_q     <= RST_PAR_TYP;
      prescale_q    <= RST_PRESCALE;
      sh_par_en_q   <= RST_PAR_EN;
      sh_par_typ_q  <= RST_PAR_TYP;
      sh_prescale_q <= RST_PRESCALE;
      cfg_pending_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_rx_q     <= prev_rx_d;
      idle_cnt_q    <= idle_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      par_en_q      <= par_en_d;
      par_typ_q     <= par_typ_d;
      prescale_q    <= prescale_d;
      sh_par_en_q   <= sh_par_en_d;
      sh_par_typ_q  <= sh_par_typ_d;
      sh_prescale_q <= sh_prescale_d;
      cfg_pending_q <= cfg_pending_d;
      cfg_err_q     <= cfg_err_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign PAR_EN      = par_en_q;
  assign PAR_TYP     = par_typ_q;
  assign Prescale    = prescale_q;
  assign cfg_pending = cfg_pending_q;
  assign cfg_err     = cfg_err_q;
  assign frame_err   = frame_err_q;

  rx_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .in_valid (data_valid),
    .in_data  (P_DATA),
    .out_ready(m_ready),
    .out_data (m_data),
    .out_valid(m_valid),
    .count    (fifo_count),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       cfg_wr, cfg_par_en, cfg_par_typ;
  logic [5:0] cfg_prescale;
  logic       PAR_EN, PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic [7:0] m_data;
  logic       m_valid, m_ready;
  logic [3:0] fifo_count;
  logic       cfg_pending, cfg_err, frame_err, overrun, ovr_clr;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(.FIFO_DEPTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN),
    .cfg_wr(cfg_wr), .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ),
    .cfg_prescale(cfg_prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
    .P_DATA(P_DATA), .data_valid(data_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .fifo_count(fifo_count), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .frame_err(frame_err), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit expect_out);
    data_valid = 1'b1;
    P_DATA     = b;
    if (expect_out) exp_q.push_back(b);
  endtask

  task automatic write_cfg(input logic en, input logic typ, input logic [5:0] p);
    cfg_wr       = 1'b1;
    cfg_par_en   = en;
    cfg_par_typ  = typ;
    cfg_prescale = p;
  endtask

  // Scoreboard monitor: every accepted head byte must match the oldest expected byte.
  always @(negedge CLK) begin
    if (!RST && m_valid && m_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got %0h expected none at %0t", m_data, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (m_data !== e) begin
          bad++;
          $display("FAIL pop_data: got %0h expected %0h at %0t", m_data, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; RX_IN = 1'b1; cfg_wr = 1'b0; cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
    cfg_prescale = 6'd0; P_DATA = 8'h00; data_valid = 1'b0; m_ready = 1'b1; ovr_clr = 1'b0;
    tick(2);
    check("rst_par_en", PAR_EN, 1);
    check("rst_par_typ", PAR_TYP, 0);
    check("rst_prescale", Prescale, 8);
    check("rst_pending", cfg_pending, 0);
    check("rst_errs", {cfg_err, frame_err, overrun}, 0);
    check("rst_fifo", {m_valid, fifo_count, m_data}, 0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE_WAIT));
    RST = 1'b0;

    // Idle line: 2*8 cycles to reach IDLE.
    tick(15);
    check("idle_15", 32'(dut.state_q), 32'(IDLE_WAIT));
    tick(1);
    check("idle_16", 32'(dut.state_q), 32'(IDLE));

    // Config write during a frame is held until the line has been idle again.
    RX_IN = 1'b0;
    tick(1);
    check("frame_entry", 32'(dut.state_q), 32'(FRAME));
    RX_IN = 1'b1;
    write_cfg(1'b0, 1'b0, 6'd16);
    tick(1);
    cfg_wr = 1'b0;
    check("mid_pending", cfg_pending, 1);
    check("mid_cfg_hold", {PAR_EN, Prescale}, {1'b1, 6'd8});
    tick(5);
    push_byte(8'hA5, 1'b1);
    tick(1);
    data_valid = 1'b0;
    tick(16);
    check("apply_wait_cfg", {PAR_EN, Prescale, cfg_pending}, {1'b1, 6'd8, 1'b1});
    check("apply_wait_state", 32'(dut.state_q), 32'(IDLE));
    tick(1);
    check("apply_cfg", {PAR_EN, Prescale, cfg_pending}, {1'b0, 6'd16, 1'b0});

    // Illegal prescale: error pulse, nothing else changes.
    write_cfg(1'b1, 1'b1, 6'd12);
    tick(1);
    cfg_wr = 1'b0;
    check("bad_cfg_err", cfg_err, 1);
    check("bad_cfg_state", {PAR_EN, PAR_TYP, Prescale, cfg_pending}, {1'b0, 1'b0, 6'd16, 1'b0});
    tick(1);
    check("bad_cfg_pulse_end", cfg_err, 0);
    tick(1);
    check("bad_cfg_no_apply", {PAR_EN, PAR_TYP, Prescale}, {1'b0, 1'b0, 6'd16});

    // Write coinciding with an apply: old shadow applied, new one stays pending.
    write_cfg(1'b1, 1'b1, 6'd32);
    tick(1);
    check("wr32_pending", {cfg_pending, Prescale}, {1'b1, 6'd16});
    write_cfg(1'b1, 1'b0, 6'd8);
    tick(1);
    cfg_wr = 1'b0;
    check("coincide_apply", {PAR_EN, PAR_TYP, Prescale, cfg_pending}, {1'b1, 1'b1, 6'd32, 1'b1});
    tick(1);
    check("second_apply", {PAR_EN, PAR_TYP, Prescale, cfg_pending}, {1'b1, 1'b0, 6'd8, 1'b0});

    // Frame timeout at prescale 8: 12*8 = 96 cycles.
    RX_IN = 1'b0;
    tick(1);
    RX_IN = 1'b1;
    tick(95);
    check("tmo_95", frame_err, 0);
    tick(1);
    check("tmo_96", frame_err, 1);
    check("tmo_state", 32'(dut.state_q), 32'(IDLE_WAIT));
    tick(1);
    check("tmo_pulse_end", frame_err, 0);
    tick(16);
    check("tmo_back_idle", 32'(dut.state_q), 32'(IDLE));

    // data_valid on the timeout cycle wins.
    RX_IN = 1'b0;
    tick(1);
    RX_IN = 1'b1;
    tick(95);
    push_byte(8'h3C, 1'b1);
    tick(1);
    data_valid = 1'b0;
    check("dv_wins_err", frame_err, 0);
    check("dv_wins_state", 32'(dut.state_q), 32'(IDLE_WAIT));
    tick(1);
    check("dv_wins_err2", frame_err, 0);

    // Fill past full with consumer stalled.
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      push_byte(8'(i), i <= 8);
      tick(1);
    end
    data_valid = 1'b0;
    check("full_count", fifo_count, 8);
    check("full_overrun", overrun, 1);
    check("full_head", {m_valid, m_data}, {1'b1, 8'h01});
    push_byte(8'h0A, 1'b1);
    m_ready = 1'b1;
    tick(1);
    data_valid = 1'b0;
    m_ready    = 1'b0;
    check("full_pushpop_count", fifo_count, 8);
    check("full_pushpop_head", m_data, 8'h02);
    ovr_clr = 1'b1;
    tick(1);
    check("ovr_clr", overrun, 0);
    push_byte(8'hEE, 1'b0);
    tick(1);
    data_valid = 1'b0;
    ovr_clr    = 1'b0;
    check("ovr_set_wins", overrun, 1);
    ovr_clr = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    check("ovr_clr2", overrun, 0);
    m_ready = 1'b1;
    tick(10);
    check("drained", {m_valid, fifo_count, m_data}, 0);

    // Async reset during a frame with bytes queued and a non-reset config.
    m_ready = 1'b0;
    tick(20);
    check("pre_rst_idle", 32'(dut.state_q), 32'(IDLE));
    write_cfg(1'b0, 1'b1, 6'd16);
    tick(1);
    cfg_wr = 1'b0;
    tick(1);
    check("pre_rst_cfg", {PAR_EN, PAR_TYP, Prescale}, {1'b0, 1'b1, 6'd16});
    for (int i = 0; i < 3; i++) begin
      push_byte(8'h50 + 8'(i), 1'b0);
      tick(1);
    end
    data_valid = 1'b0;
    RX_IN = 1'b0;
    tick(1);
    RX_IN = 1'b1;
    check("pre_rst_frame", {32'(dut.state_q), 32'(fifo_count)}, {32'(FRAME), 32'd3});
    #2;
    RST = 1'b1;
    #1;
    check("async_rst_fifo", {m_valid, fifo_count}, 0);
    check("async_rst_state", 32'(dut.state_q), 32'(IDLE_WAIT));
    check("async_rst_cfg", {PAR_EN, PAR_TYP, Prescale, cfg_pending}, {1'b1, 1'b0, 6'd8, 1'b0});
    tick(1);
    RST = 1'b0;
    tick(2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
